dot_mac_pipe: RTL and testbench

- Parametrised, pipelined dot-product MAC. Successor of the single-cycle int8 dot-product cell.
- Each accepted beat computes a LANES-wide dot product in u8, s8 or packed s4 mode.
- Beats are accumulated across a K-dimension burst delimited by in_first/in_last. One saturated result is emitted per burst over a valid/ready output.
- Sits between the operand-staging buffers and the result writeback in the matrix-accelerator datapath.

---
 rtl/dot_mac_pipe_if.sv | 34 +++
 rtl/dot_mac_pipe.sv | 196 +++++++++++++++++++
 tb/tb_dot_mac_pipe.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/dot_mac_pipe_if.sv
// ---------------------------------------------------------------------------
// dot_mac_pipe_if: operand-beat and result handshake bundle for dot_mac_pipe.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dot_mac_pipe_if #(
  parameter int LANES = 32,
  parameter int ACC_W = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_first;
  logic                 in_last;
  logic [1:0]           mode;
  logic [LANES*8-1:0]   a_vec;
  logic [LANES*8-1:0]   b_vec;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_W-1:0]     out_data;
  logic                 out_ovf;

  modport master (
    output in_valid, in_first, in_last, mode, a_vec, b_vec, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_first, in_last, mode, a_vec, b_vec, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

`default_nettype wire

// File: rtl/dot_mac_pipe.sv
// ---------------------------------------------------------------------------
// dot_mac_pipe: 3-stage LANES-wide u8/s8/s4 dot-product MAC, one result per burst.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dot_mac_pipe #(
  parameter int LANES = 32,
  parameter int ACC_W = 32,
  parameter int SAT   = 1
) (
  input  wire              clk,
  input  wire              rst_n,
  dot_mac_pipe_if.slave    bus
);

  localparam int c_prod_w = 17;
  localparam int c_tree_w = c_prod_w + $clog2(LANES);
  localparam int c_ext_w  = ((ACC_W > c_tree_w) ? ACC_W : c_tree_w) + 2;

  localparam logic [1:0] c_mode_s8 = 2'b01;
  localparam logic [1:0] c_mode_s4 = 2'b10;

  localparam logic signed [c_ext_w-1:0] c_umax = c_ext_w'({ACC_W{1'b1}});
  localparam logic signed [c_ext_w-1:0] c_smax = c_ext_w'({1'b0, {(ACC_W-1){1'b1}}});
  localparam logic signed [c_ext_w-1:0] c_smin = ~c_smax;

  // ---------------- handshake ----------------
  logic r_alive;
  logic r_out_valid;
  logic w_stall;
  logic w_in_ready;
  logic w_accept;

  assign w_stall    = r_out_valid & ~bus.out_ready;
  assign w_in_ready = r_alive & ~w_stall;
  assign w_accept   = bus.in_valid & w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_alive <= 1'b0;
    else        r_alive <= 1'b1;
  end

  // ---------------- per-lane products ----------------
  logic w_is_s8;
  logic w_is_s4;
  logic signed [c_prod_w-1:0] w_prod [LANES];

  assign w_is_s8 = (bus.mode == c_mode_s8);
  assign w_is_s4 = (bus.mode == c_mode_s4);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [7:0]                 w_a;
    logic [7:0]                 w_b;
    logic signed [c_prod_w-1:0] w_pu;
    logic signed [15:0]         w_ps;
    logic signed [7:0]          w_plo;
    logic signed [7:0]          w_phi;

    assign w_a   = bus.a_vec[8*j +: 8];
    assign w_b   = bus.b_vec[8*j +: 8];
    assign w_pu  = c_prod_w'($signed({1'b0, w_a})) * c_prod_w'($signed({1'b0, w_b}));
    assign w_ps  = 16'($signed(w_a)) * 16'($signed(w_b));
    assign w_plo = 8'($signed(w_a[3:0])) * 8'($signed(w_b[3:0]));
    assign w_phi = 8'($signed(w_a[7:4])) * 8'($signed(w_b[7:4]));

    // Nibble pair sum can reach +128, so both halves widen before adding.
    assign w_prod[j] = w_is_s4 ? (c_prod_w'(w_plo) + c_prod_w'(w_phi)) :
                       w_is_s8 ? c_prod_w'(w_ps) : w_pu;
  end

  // ---------------- P1: products + sideband ----------------
  logic                       r_p1_valid;
  logic                       r_p1_sgn;
  logic                       r_p1_first;
  logic                       r_p1_last;
  logic signed [c_prod_w-1:0] r_p1_prod [LANES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_valid <= 1'b0;
      r_p1_sgn   <= 1'b0;
      r_p1_first <= 1'b0;
      r_p1_last  <= 1'b0;
      for (int j = 0; j < LANES; j++) r_p1_prod[j] <= '0;
    end else if (!w_stall) begin
      r_p1_valid <= w_accept;
      if (w_accept) begin
        r_p1_sgn   <= w_is_s8 | w_is_s4;
        r_p1_first <= bus.in_first;
        r_p1_last  <= bus.in_last;
        for (int j = 0; j < LANES; j++) r_p1_prod[j] <= w_prod[j];
      end
    end
  end

  // ---------------- P2: adder tree ----------------
  logic signed [c_tree_w-1:0] w_tree;

  always_comb begin
    w_tree = '0;
    for (int j = 0; j < LANES; j++) w_tree = w_tree + c_tree_w'(r_p1_prod[j]);
  end

  logic                       r_p2_valid;
  logic                       r_p2_sgn;
  logic                       r_p2_first;
  logic                       r_p2_last;
  logic signed [c_tree_w-1:0] r_p2_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p2_valid <= 1'b0;
      r_p2_sgn   <= 1'b0;
      r_p2_first <= 1'b0;
      r_p2_last  <= 1'b0;
      r_p2_sum   <= '0;
    end else if (!w_stall) begin
      r_p2_valid <= r_p1_valid;
      if (r_p1_valid) begin
        r_p2_sgn   <= r_p1_sgn;
        r_p2_first <= r_p1_first;
        r_p2_last  <= r_p1_last;
        r_p2_sum   <= w_tree;
      end
    end
  end

  // ---------------- P3: accumulate, clamp/wrap, output ----------------
  logic [ACC_W-1:0]          r_acc;
  logic                      r_sticky;
  logic [ACC_W-1:0]          r_out_data;
  logic                      r_out_ovf;
  logic signed [c_ext_w-1:0] w_base;
  logic signed [c_ext_w-1:0] w_sum;
  logic                      w_hi;
  logic                      w_lo;
  logic                      w_ovf;
  logic                      w_sticky_base;
  logic [ACC_W-1:0]          w_res;

  // The stored accumulator is reinterpreted by the mode of the arriving beat.
  always_comb begin
    if (r_p2_first)    w_base = '0;
    else if (r_p2_sgn) w_base = c_ext_w'($signed(r_acc));
    else               w_base = c_ext_w'($signed({1'b0, r_acc}));
    w_sum = w_base + c_ext_w'(r_p2_sum);
  end

  always_comb begin
    w_hi          = r_p2_sgn ? (w_sum > c_smax) : (w_sum > c_umax);
    w_lo          = r_p2_sgn ? (w_sum < c_smin) : w_sum[c_ext_w-1];
    w_ovf         = w_hi | w_lo;
    w_sticky_base = r_p2_first ? 1'b0 : r_sticky;
    w_res         = w_sum[ACC_W-1:0];
    if (SAT != 0) begin
      if (w_hi)      w_res = r_p2_sgn ? c_smax[ACC_W-1:0] : c_umax[ACC_W-1:0];
      else if (w_lo) w_res = r_p2_sgn ? c_smin[ACC_W-1:0] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_sticky    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else if (!w_stall) begin
      if (r_p2_valid && r_p2_last) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_res;
        r_out_ovf   <= w_sticky_base | w_ovf;
      end else begin
        r_out_valid <= 1'b0;
      end
      if (r_p2_valid) begin
        if (r_p2_last) begin
          r_acc    <= '0;
          r_sticky <= 1'b0;
        end else begin
          r_acc    <= w_res;
          r_sticky <= w_sticky_base | w_ovf;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ovf   = r_out_ovf;

endmodule

`default_nettype wire

// File: tb/tb_dot_mac_pipe.sv
// ---------------------------------------------------------------------------
// tb_dot_mac_pipe: directed vectors for dot_mac_pipe at ACC_W=32 and ACC_W=17 (SAT on/off).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dot_mac_pipe;
  localparam int LANES = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               tb_valid  = 1'b0;
  logic               tb_first  = 1'b0;
  logic               tb_last   = 1'b0;
  logic               tb_oready = 1'b1;
  logic [1:0]         tb_mode   = 2'b00;
  logic [LANES*8-1:0] tb_a      = '0;
  logic [LANES*8-1:0] tb_b      = '0;

  int n_total = 0;
  int n_bad   = 0;

  dot_mac_pipe_if #(.LANES(LANES), .ACC_W(32)) if32 ();
  dot_mac_pipe_if #(.LANES(LANES), .ACC_W(17)) if17s ();
  dot_mac_pipe_if #(.LANES(LANES), .ACC_W(17)) if17w ();

  assign if32.in_valid  = tb_valid;  assign if32.in_first  = tb_first;  assign if32.in_last  = tb_last;
  assign if32.mode      = tb_mode;   assign if32.a_vec     = tb_a;      assign if32.b_vec    = tb_b;
  assign if32.out_ready = tb_oready;
  assign if17s.in_valid = tb_valid;  assign if17s.in_first = tb_first;  assign if17s.in_last = tb_last;
  assign if17s.mode     = tb_mode;   assign if17s.a_vec    = tb_a;      assign if17s.b_vec   = tb_b;
  assign if17s.out_ready = tb_oready;
  assign if17w.in_valid = tb_valid;  assign if17w.in_first = tb_first;  assign if17w.in_last = tb_last;
  assign if17w.mode     = tb_mode;   assign if17w.a_vec    = tb_a;      assign if17w.b_vec   = tb_b;
  assign if17w.out_ready = tb_oready;

  dot_mac_pipe #(.LANES(LANES), .ACC_W(32), .SAT(1)) u_dut32  (.clk(clk), .rst_n(rst_n), .bus(if32));
  dot_mac_pipe #(.LANES(LANES), .ACC_W(17), .SAT(1)) u_dut17s (.clk(clk), .rst_n(rst_n), .bus(if17s));
  dot_mac_pipe #(.LANES(LANES), .ACC_W(17), .SAT(0)) u_dut17w (.clk(clk), .rst_n(rst_n), .bus(if17w));

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] exp;
    logic        ovf;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic put(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                     input logic f, input logic l);
    int n;
    n = 0;
    tb_mode = m; tb_a = {LANES{a}}; tb_b = {LANES{b}};
    tb_first = f; tb_last = l; tb_valid = 1'b1;
    while (!if32.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!if32.in_ready) begin
      n_total++; n_bad++;
      $display("FAIL put_timeout: in_ready=0 after %0d cycles, expected 1", n);
    end
    @(posedge clk); #1;
    tb_valid = 1'b0;
  endtask

  task automatic get(input string nm, input logic [31:0] e, input logic eo, input bit c17,
                     input logic [16:0] es, input logic eso, input logic [16:0] ew,
                     input logic ewo, output int lat);
    int n;
    n = 0;
    tb_oready = 1'b1;
    while (!if32.out_valid && n < 40) begin @(posedge clk); #1; n++; end
    lat = n;
    if (!if32.out_valid) begin
      n_total++; n_bad++;
      $display("FAIL %s_timeout: out_valid=0 after %0d cycles, expected 1", nm, n);
    end else begin
      chk({nm, "_data"}, if32.out_data, e);
      chk({nm, "_ovf"}, 32'(if32.out_ovf), 32'(eo));
      if (c17) begin
        chk({nm, "_sat17_data"},  32'(if17s.out_data), 32'(es));
        chk({nm, "_sat17_ovf"},   32'(if17s.out_ovf),  32'(eso));
        chk({nm, "_wrap17_data"}, 32'(if17w.out_data), 32'(ew));
        chk({nm, "_wrap17_ovf"},  32'(if17w.out_ovf),  32'(ewo));
      end
      @(posedge clk); #1;
    end
  endtask

  // Holds the consumer off for 5 cycles while four single-beat bursts queue up.
  task automatic stall_collect();
    int n;
    int lat;
    n = 0;
    while (!if32.out_valid && n < 40) begin @(posedge clk); #1; n++; end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_in_ready_%0d", k), 32'(if32.in_ready), 32'd0);
      chk($sformatf("stall_hold_%0d", k), if32.out_data, 32'd224);
      @(posedge clk); #1;
    end
    get("burst7",  32'd224, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, lat);
    get("burst8",  32'd256, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, lat);
    get("burst9",  32'd288, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, lat);
    get("burst10", 32'd320, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    tbl[0] = '{2'b00, 8'h03, 8'h05, 32'd480,       1'b0};
    tbl[1] = '{2'b01, 8'h80, 8'h7F, -32'sd520192,  1'b0};
    tbl[2] = '{2'b10, 8'h88, 8'h77, -32'sd3584,    1'b0};
    tbl[3] = '{2'b11, 8'h80, 8'h02, 32'd8192,      1'b0};
    tbl[4] = '{2'b00, 8'hFF, 8'hFF, 32'd2080800,   1'b0};
    tbl[5] = '{2'b01, 8'hFF, 8'hFF, 32'd32,        1'b0};
    tbl[6] = '{2'b01, 8'h80, 8'h80, 32'd524288,    1'b0};
    tbl[7] = '{2'b10, 8'h1F, 8'h23, -32'sd32,      1'b0};
    tbl[8] = '{2'b00, 8'h80, 8'h02, 32'd8192,      1'b0};
    tbl[9] = '{2'b01, 8'h7F, 8'hFF, -32'sd4064,    1'b0};

    #12;
    chk("rst_in_ready",  32'(if32.in_ready),  32'd0);
    chk("rst_out_valid", 32'(if32.out_valid), 32'd0);
    chk("rst_out_data",  if32.out_data,       32'd0);
    chk("rst_out_ovf",   32'(if32.out_ovf),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(if32.in_ready), 32'd1);

    put(2'b00, 8'd3, 8'd5, 1'b1, 1'b1);
    get("u8_first", 32'd480, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, lat);
    chk("u8_latency", 32'(lat), 32'd2);

    for (int i = 0; i < 10; i++) begin
      put(tbl[i].mode, tbl[i].a, tbl[i].b, 1'b1, 1'b1);
      get($sformatf("vec%0d", i), tbl[i].exp, tbl[i].ovf, 1'b0, '0, 1'b0, '0, 1'b0, lat);
    end

    put(2'b01, 8'h80, 8'h7F, 1'b1, 1'b0);
    put(2'b01, 8'h80, 8'h7F, 1'b0, 1'b0);
    put(2'b01, 8'h80, 8'h7F, 1'b0, 1'b0);
    put(2'b01, 8'h80, 8'h7F, 1'b0, 1'b1);
    get("s8_burst", -32'sd2080768, 1'b0, 1'b1, 17'h10000, 1'b1, 17'h04000, 1'b1, lat);

    put(2'b00, 8'hFF, 8'hFF, 1'b1, 1'b0);
    put(2'b00, 8'hFF, 8'hFF, 1'b0, 1'b0);
    put(2'b00, 8'hFF, 8'hFF, 1'b0, 1'b1);
    get("u8_burst", 32'd6242400, 1'b0, 1'b1, 17'h1FFFF, 1'b1, 17'd82016, 1'b1, lat);

    put(2'b00, 8'd3, 8'd5, 1'b1, 1'b1);
    get("pre_nofirst", 32'd480, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, lat);
    put(2'b00, 8'd1, 8'd1, 1'b0, 1'b1);
    get("nofirst", 32'd32, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, lat);

    put(2'b00, 8'd10, 8'd10, 1'b1, 1'b0);
    put(2'b00, 8'd1, 8'd1, 1'b1, 1'b1);
    get("first_mid", 32'd32, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, lat);

    put(2'b00, 8'd2, 8'd3, 1'b1, 1'b0);
    put(2'b10, 8'h12, 8'h13, 1'b0, 1'b1);
    get("mode_mix", 32'd416, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, lat);

    tb_oready = 1'b0;
    fork
      begin
        put(2'b00, 8'd7,  8'd1, 1'b1, 1'b1);
        put(2'b00, 8'd8,  8'd1, 1'b1, 1'b1);
        put(2'b00, 8'd9,  8'd1, 1'b1, 1'b1);
        put(2'b00, 8'd10, 8'd1, 1'b1, 1'b1);
      end
      stall_collect();
    join
    tb_oready = 1'b1;

    put(2'b00, 8'd50, 8'd50, 1'b1, 1'b0);
    put(2'b00, 8'd50, 8'd50, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(if32.out_valid), 32'd0);
    chk("midrst_in_ready",  32'(if32.in_ready),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    put(2'b00, 8'd1, 8'd1, 1'b0, 1'b1);
    get("rst_resid", 32'd32, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, lat);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
